// File: rtl/fp_mult_stim_gen_if.sv
// Operand/expectation bus between fp_mult_stim_gen and the multiplier under test.
// The master modport is the stimulus generator's side of the bus.
interface fp_mult_stim_gen_if;
  logic        start;
  logic        op_ready;
  logic        op_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        exp_valid;
  logic [7:0]  exp_status;
  logic [7:0]  exp_mask;
  logic [5:0]  pair_count;
  logic        busy;
  logic        done;

  modport master (
    input  start, op_ready,
    output op_valid, a, b, exp_valid, exp_status, exp_mask, pair_count, busy, done
  );

  modport slave (
    output start, op_ready,
    input  op_valid, a, b, exp_valid, exp_status, exp_mask, pair_count, busy, done
  );
endinterface

// File: rtl/fp_mult_stim_gen.sv
// Walks every ordered pair of FP32 operand classes into a multiplier and emits the
// expected status/care-mask LATENCY cycles later. FP_STIM_NAN_EN adds the NaN class.
module fp_mult_stim_gen #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned ROUNDS  = 1,
  parameter logic [31:0] SEED    = 32'hACE1_2345
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_mult_stim_gen_if.master   stim
);

`ifdef FP_STIM_NAN_EN
  localparam logic [2:0] NCLS = 3'd6;
`else
  localparam logic [2:0] NCLS = 3'd5;
`endif
  localparam int          LAT        = int'(LATENCY);
  localparam logic [2:0]  LAST_CLS   = NCLS - 3'd1;
  localparam logic [7:0]  LAST_ROUND = 8'(ROUNDS - 1);
  localparam logic [3:0]  LAST_DRAIN = 4'(LATENCY - 1);
  localparam logic [31:0] SEED_EFF   = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cls_a_q, cls_a_d, cls_b_q, cls_b_d;
  logic [5:0]  pair_q, pair_d;
  logic [7:0]  round_q, round_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [3:0]  drain_q, drain_d;
  logic        transfer_s;
  logic [15:0] stage0_s;

  logic        op_valid_q, busy_q, done_q;
  logic [31:0] a_q, b_q;
  logic [5:0]  pair_count_q;
  logic        pv_q [LAT];
  logic [7:0]  ps_q [LAT];
  logic [7:0]  pm_q [LAT];

  function automatic logic [31:0] lfsr_step(input logic [31:0] r);
    return {1'b0, r[31:1]} ^ (r[0] ? LFSR_TAPS : 32'd0);
  endfunction

  function automatic logic [31:0] gen_operand(input logic [2:0] cls, input logic [31:0] r);
    logic [5:0]  e6;
    logic [7:0]  exp_norm;
    logic [31:0] v;
    e6       = (r[5:0] == 6'd63) ? 6'd0 : r[5:0];
    exp_norm = 8'd96 + {2'b00, e6};
    case (cls)
      3'd0:    v = {r[31], 8'd0,   23'd0};
      3'd1:    v = {r[31], 8'd1,   23'd0};
      3'd2:    v = {r[31], exp_norm, r[22:0]};
      3'd3:    v = {r[31], 8'd254, 23'h7F_FFFF};
      3'd4:    v = {r[31], 8'd255, 23'd0};
`ifdef FP_STIM_NAN_EN
      3'd5:    v = {r[31], 8'd255, r[22:1], 1'b1};
`endif
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  // Classes 4/5 (INF, NaN) are the "special" operands; result is {status, mask}.
  function automatic logic [15:0] expect_of(input logic [2:0] ca, input logic [2:0] cb);
    logic za, zb, spa, spb;
    logic [15:0] r;
    za  = (ca == 3'd0);
    zb  = (cb == 3'd0);
    spa = (ca >= 3'd4);
    spb = (cb >= 3'd4);
    if ((za && spb) || (zb && spa)) begin
      r = {8'h04, 8'h07};
    end else if (za || zb) begin
      r = {8'h01, 8'h07};
    end else if (spa || spb) begin
      r = {8'h02, 8'h07};
    end else if ((ca == 3'd2) && (cb == 3'd2)) begin
      r = {8'h00, 8'h1F};
    end else begin
      r = {8'h00, 8'h04};
    end
    return r;
  endfunction

  assign transfer_s = (state_q == S_ISSUE) && stim.op_ready;
  assign stage0_s   = transfer_s ? expect_of(cls_a_q, cls_b_q) : 16'd0;

  // Next-state logic: pair/round sequencing and drain countdown.
  always_comb begin
    state_d = state_q;
    cls_a_d = cls_a_q;
    cls_b_d = cls_b_q;
    pair_d  = pair_q;
    round_d = round_q;
    lfsr_d  = lfsr_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (stim.start) begin
          state_d = S_ISSUE;
          cls_a_d = 3'd0;
          cls_b_d = 3'd0;
          pair_d  = 6'd0;
          round_d = 8'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_ISSUE: begin
        if (transfer_s) begin
          lfsr_d = lfsr_step(lfsr_q);
          if (cls_b_q == LAST_CLS) begin
            cls_b_d = 3'd0;
            if (cls_a_q == LAST_CLS) begin
              cls_a_d = 3'd0;
              pair_d  = 6'd0;
              if (round_q == LAST_ROUND) begin
                state_d = S_DRAIN;
                drain_d = 4'd0;
              end else begin
                round_d = round_q + 8'd1;
              end
            end else begin
              cls_a_d = cls_a_q + 3'd1;
              pair_d  = pair_q + 6'd1;
            end
          end else begin
            cls_b_d = cls_b_q + 3'd1;
            pair_d  = pair_q + 6'd1;
          end
        end else begin
          lfsr_d = lfsr_q;
        end
      end
      S_DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and LFSR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_a_q <= 3'd0;
      cls_b_q <= 3'd0;
      pair_q  <= 6'd0;
      round_q <= 8'd0;
      lfsr_q  <= SEED_EFF;
      drain_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cls_a_q <= cls_a_d;
      cls_b_q <= cls_b_d;
      pair_q  <= pair_d;
      round_q <= round_d;
      lfsr_q  <= lfsr_d;
      drain_q <= drain_d;
    end
  end

  // Operand outputs are registered from next state, so they track state_q without lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid_q   <= 1'b0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      pair_count_q <= 6'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      op_valid_q   <= (state_d == S_ISSUE);
      a_q          <= (state_d == S_ISSUE) ? gen_operand(cls_a_d, lfsr_d) : 32'd0;
      b_q          <= (state_d == S_ISSUE) ? gen_operand(cls_b_d, {lfsr_d[15:0], lfsr_d[31:16]}) : 32'd0;
      pair_count_q <= pair_d;
      busy_q       <= (state_d == S_ISSUE) || (state_d == S_DRAIN);
      done_q       <= (state_d == S_DONE);
    end
  end

  // Expectation delay line, shifts every cycle regardless of handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pv_q[i] <= 1'b0;
        ps_q[i] <= 8'd0;
        pm_q[i] <= 8'd0;
      end
    end else begin
      pv_q[0] <= transfer_s;
      ps_q[0] <= stage0_s[15:8];
      pm_q[0] <= stage0_s[7:0];
      for (int i = 1; i < LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        ps_q[i] <= ps_q[i-1];
        pm_q[i] <= pm_q[i-1];
      end
    end
  end

  assign stim.op_valid   = op_valid_q;
  assign stim.a          = a_q;
  assign stim.b          = b_q;
  assign stim.pair_count = pair_count_q;
  assign stim.busy       = busy_q;
  assign stim.done       = done_q;
  assign stim.exp_valid  = pv_q[LAT-1];
  assign stim.exp_status = ps_q[LAT-1];
  assign stim.exp_mask   = pm_q[LAT-1];

endmodule

// File: tb/tb_fp_mult_stim_gen.sv
// Directed bench for fp_mult_stim_gen: class-field operand checks, scoreboarded
// expectations with exact latency, stall, mid-run reset and reseed behaviour.
module tb_fp_mult_stim_gen;
  localparam int LAT = 3;
`ifdef FP_STIM_NAN_EN
  localparam int NCLS    = 6;
  localparam int DONE_AT = 40;
`else
  localparam int NCLS    = 5;
  localparam int DONE_AT = 29;
`endif
  localparam int NPAIRS = NCLS * NCLS;

  typedef struct {
    logic [7:0] st;
    logic [7:0] mk;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   idx, run_id, xfers, t0;
  int   mon_ca, mon_cb;
  logic [15:0] mon_e;
  exp_t mon_ent;
  exp_t sb[$];
  logic [31:0] rec_a [4];
  logic [31:0] rec_b [4];
  logic [31:0] hold_a, hold_b, hold_pc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fp_mult_stim_gen_if bus ();

  fp_mult_stim_gen #(.LATENCY(LAT), .ROUNDS(1), .SEED(32'hACE1_2345)) dut (
    .clk  (clk),
    .rst  (rst),
    .stim (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_exp(input int ca, input int cb);
    bit az, bz, asp, bsp;
    az  = (ca == 0);
    bz  = (cb == 0);
    asp = (ca == 4) || (ca == 5);
    bsp = (cb == 4) || (cb == 5);
    if ((az && bsp) || (bz && asp)) return 16'h0407;
    if (az || bz)                   return 16'h0107;
    if (asp || bsp)                 return 16'h0207;
    if (ca == 2 && cb == 2)         return 16'h001F;
    return 16'h0004;
  endfunction

  task automatic chk_operand(input string tag, input logic [31:0] v, input int cls);
    logic [7:0] e;
    e = v[30:23];
    case (cls)
      0: chk(tag, {1'b0, v[30:0]}, 32'h0000_0000);
      1: chk(tag, {1'b0, v[30:0]}, 32'h0080_0000);
      2: chk(tag, {31'd0, (e >= 8'd96) && (e <= 8'd158)}, 32'd1);
      3: chk(tag, {1'b0, v[30:0]}, 32'h7F7F_FFFF);
      4: chk(tag, {1'b0, v[30:0]}, 32'h7F80_0000);
      5: chk(tag, {30'd0, e == 8'd255, v[0]}, 32'd3);
      default: ;
    endcase
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_op_valid"},   32'(bus.op_valid),   32'd0);
    chk({tag, "_a"},          bus.a,               32'd0);
    chk({tag, "_b"},          bus.b,               32'd0);
    chk({tag, "_exp_valid"},  32'(bus.exp_valid),  32'd0);
    chk({tag, "_exp_status"}, 32'(bus.exp_status), 32'd0);
    chk({tag, "_exp_mask"},   32'(bus.exp_mask),   32'd0);
    chk({tag, "_pair_count"}, 32'(bus.pair_count), 32'd0);
    chk({tag, "_busy"},       32'(bus.busy),       32'd0);
    chk({tag, "_done"},       32'(bus.done),       32'd0);
  endtask

  task automatic do_start(output int t);
    @(posedge clk); #1;
    bus.start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int t, input int extra);
    int n;
    n = 0;
    while (!bus.done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_cycle", 32'(cyc), 32'(t + DONE_AT + extra));
    chk("busy_at_done", 32'(bus.busy), 32'd0);
  endtask

  // Monitor: check each transfer against the class table and scoreboard its expectation.
  always @(negedge clk) begin
    if (bus.op_valid && bus.op_ready) begin
      mon_ca = idx / NCLS;
      mon_cb = idx % NCLS;
      chk("pair_count", 32'(bus.pair_count), 32'(idx));
      chk_operand("a_class", bus.a, mon_ca);
      chk_operand("b_class", bus.b, mon_cb);
      mon_e = model_exp(mon_ca, mon_cb);
      sb.push_back('{mon_e[15:8], mon_e[7:0], cyc + LAT});
      if (run_id == 1 && idx < 4) begin
        rec_a[idx] = bus.a;
        rec_b[idx] = bus.b;
      end
      if (run_id == 4 && idx < 4) begin
        chk("reseed_a", bus.a, rec_a[idx]);
        chk("reseed_b", bus.b, rec_b[idx]);
      end
      idx = (idx + 1) % NPAIRS;
      xfers++;
    end
    if (bus.exp_valid) begin
      if (sb.size() == 0) begin
        chk("exp_valid_unexpected", 32'd1, 32'd0);
      end else begin
        mon_ent = sb.pop_front();
        chk("exp_status",  32'(bus.exp_status), 32'(mon_ent.st));
        chk("exp_mask",    32'(bus.exp_mask),   32'(mon_ent.mk));
        chk("exp_latency", 32'(cyc),            32'(mon_ent.due));
      end
    end
  end

  initial begin
    bus.start    = 1'b0;
    bus.op_ready = 1'b0;
    rst    = 1'b1;
    idx    = 0;
    run_id = 0;
    xfers  = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("idle");

    // Run 1: full pass with op_ready held high.
    run_id = 1; idx = 0; xfers = 0;
    bus.op_ready = 1'b1;
    do_start(t0);
    @(negedge clk);
    chk("op_valid_t1", 32'(bus.op_valid), 32'd1);
    chk("first_a_exp", 32'(bus.a[30:23]), 32'd0);
    chk("first_b_exp", 32'(bus.b[30:23]), 32'd0);
    wait_done(t0, 0);
    chk("run1_xfers", 32'(xfers), 32'(NPAIRS));
    chk("run1_sb_empty", 32'(sb.size()), 32'd0);

    // Run 2: five-cycle stall mid-ISSUE with start held (ignored).
    run_id = 2; idx = 0; xfers = 0;
    do_start(t0);
    repeat (5) @(posedge clk);
    #1;
    bus.op_ready = 1'b0;
    bus.start    = 1'b1;
    @(negedge clk);
    hold_a  = bus.a;
    hold_b  = bus.b;
    hold_pc = 32'(bus.pair_count);
    repeat (4) begin
      @(negedge clk);
      chk("stall_a", bus.a, hold_a);
      chk("stall_b", bus.b, hold_b);
      chk("stall_pc", 32'(bus.pair_count), hold_pc);
      chk("stall_op_valid", 32'(bus.op_valid), 32'd1);
      if (cyc >= t0 + 9) chk("stall_no_exp", 32'(bus.exp_valid), 32'd0);
    end
    @(posedge clk); #1;
    bus.op_ready = 1'b1;
    bus.start    = 1'b0;
    wait_done(t0, 5);
    chk("run2_xfers", 32'(xfers), 32'(NPAIRS));

    // Run 3: reset with two expectations still in flight.
    run_id = 3; idx = 0;
    do_start(t0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.op_ready = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk);
    check_quiet("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (LAT + 1) @(posedge clk);

    // Run 4: restart after reset must replay the seeded sequence.
    run_id = 4; idx = 0; xfers = 0;
    bus.op_ready = 1'b1;
    do_start(t0);
    wait_done(t0, 0);
    chk("run4_xfers", 32'(xfers), 32'(NPAIRS));

    repeat (LAT + 2) @(posedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_mult_stim_gen.md
# fp_mult_stim_gen

Self-sequencing operand source for the pipelined FP32 multiplier. Drives every ordered pair of IEEE-754 operand classes into the multiplier's a/b inputs over a valid/ready handshake. Emits, LATENCY cycles after each accepted pair, the expected status byte plus a care-mask, aligned with the multiplier's z/status outputs so a status checker or scoreboard can compare them directly.

## Interface
- LATENCY, 3: multiplier input-to-output latency in cycles (1..8)
- ROUNDS, 1: full passes over the class-pair table per start (1..255)
- SEED, 32'hACE1_2345: LFSR reset value; 0 is replaced by 1
- clk  in  1  clock; everything on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- op_ready  in  1  multiplier accepts operands this cycle
- op_valid  out  1  a/b hold a valid pair
- a  out  32  operand A
- b  out  32  operand B
- exp_valid  out  1  exp_status/exp_mask valid, aligned with multiplier output
- exp_status  out  8  expected status: [0] zero, [1] inf, [2] nan, [3] tiny, [4] huge, [7:5] 0
- exp_mask  out  8  1 = bit of exp_status must match
- pair_count  out  6  index of the pair currently presented
- busy  out  1  state is ISSUE or DRAIN
- done  out  1  level, high in DONE

## Operation
- Classes: 0 ZERO (exp 0, mant 0), 1 MINN (exp 1, mant 0), 2 NORM (exp 96..158 from LFSR, mant from LFSR), 3 MAXN (exp 254, mant 7FFFFF), 4 INF (exp 255, mant 0), 5 NAN (exp 255, mant = LFSR[22:0] with bit 0 forced 1). Sign bits from LFSR. NCLS = 6.
- Pair index i: class_a = i / NCLS, class_b = i % NCLS; two nested counters, b innermost. pair_count = i.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1; advances only on a transfer (op_valid && op_ready). a/b are a combinational or registered function of counters and LFSR state, stable while stalled.
- Expected result per pair (first matching rule):
  - ZERO with INF or NAN (either order): status 0x04, mask 0x07
  - ZERO with other: 0x01, mask 0x07
  - INF or NAN with non-ZERO: 0x02, mask 0x07
  - NORM x NORM: 0x00, mask 0x1F
  - otherwise: 0x00, mask 0x04
- FSM:
  - IDLE: outputs quiet; start -> ISSUE, counters 0, round 0.
  - ISSUE: op_valid=1. On transfer advance index; after last pair of a round, round++. Transfer of the final pair of the final round -> DRAIN.
  - DRAIN: op_valid=0; counter runs LATENCY cycles -> DONE.
  - DONE: done=1; start -> ISSUE (new run, LFSR continues, not reseeded).
- start in ISSUE/DRAIN ignored.
- Expected pipeline: LATENCY-deep shift register of {valid, status, mask}, advances every cycle unconditionally; stage 0 valid = transfer.

## Timing
- Reset values: op_valid 0, a 0, b 0, exp_valid 0, exp_status 0, exp_mask 0, pair_count 0, busy 0, done 0; FSM IDLE; LFSR = SEED; shift register cleared.
- start in IDLE at cycle t -> op_valid high at t+1.
- Transfer at cycle t -> exp_valid high exactly at t+LATENCY with that pair's expectation.
- Back-to-back transfers with op_ready=1 -> one pair per cycle, exp_valid contiguous.
- Final transfer at t -> done high at t+LATENCY+1; exp_valid for the final pair coincides with the last DRAIN cycle.
- op_valid never drops without a transfer while in ISSUE.
- rst mid-run: next cycle all outputs at reset values, in-flight expectations discarded.

## Configuration
- FP_STIM_NAN_EN defined: NAN class included, NCLS=6, 36 pairs/round.
- Undefined: NAN class omitted, NCLS=5, 25 pairs/round; no operand with exp 255 and nonzero mantissa is ever generated. Rules unchanged.

## Test plan
- Reset held 3 cycles -> all outputs 0, FSM IDLE; release with no start -> outputs stay 0.
- Macro defined, ROUNDS=1, op_ready=1, start at t -> 36 transfers t+1..t+36; first a/b exps 0/0, exp_status 0x01 mask 0x07 at t+4; done at t+40.
- Pair 4 (ZERO x INF) -> b[30:0]=7F800000, exp_status 0x04 mask 0x07 LATENCY cycles after its transfer; pair 14 (NORM x NORM) -> 0x00 mask 0x1F.
- op_ready low 5 cycles mid-ISSUE -> a, b, pair_count stable, no exp_valid 3 cycles later for stall cycles, next accepted pair matches unstalled sequence.
- rst asserted with 2 entries in flight -> exp_valid never asserts for them, op_valid 0 next cycle, re-start reproduces SEED sequence.
- Macro undefined -> 25 transfers, done at t+29, no NaN operand.
